// File: rtl/nn_fifo_pkg.sv
// Shared sizing helpers for the wishbone_nn stream FIFO.
package nn_fifo_pkg;
  localparam int NN_DATA_W = 32;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/nn_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one async read port, no reset.
module nn_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/nn_stream_fifo.sv
// First-word-fall-through stream FIFO between the Wishbone front-end and the NN core,
// with occupancy/threshold flags, synchronous flush and sticky overflow/underflow.
module nn_stream_fifo
  import nn_fifo_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop,
  output logic [DATA_W-1:0]          data_o,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("nn_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("nn_stream_fifo: AFULL_LVL must lie in 1..DEPTH");
  end

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              acc_push, acc_pop;
  logic [DATA_W-1:0] rd_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_LVL));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
  assign acc_push = push && (!full || pop) && !clr;
  assign acc_pop  = pop && !empty && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (acc_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (acc_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d     = count_q + CW'(acc_push) - CW'(acc_pop);
      overflow_d  = overflow_q  | (push && full && !pop);
      underflow_d = underflow_q | (pop && empty);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  nn_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (acc_push),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Memory is never reset, so the head is gated to keep stale words invisible.
  assign data_o = empty ? '0 : rd_data;
endmodule

// File: doc/nn_stream_fifo.md
# nn_stream_fifo

Parametrised synchronous FIFO for the wishbone_nn datapath, buffering words between the Wishbone slave front-end and the neural-net compute core. It generalises the fixed 8×32 input FIFO with configurable width and depth, independent push/pop strobes, first-word-fall-through output, occupancy and threshold flags, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_LVL, DEPTH-2, almost_full asserts when count ≥ AFULL_LVL (1..DEPTH)
- clk  input  1  single clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous flush: empties FIFO, clears error flags
- push  input  1  write strobe
- data_i  input  DATA_W  write data, sampled on push
- pop  input  1  read strobe; consumes current head
- data_o  output  DATA_W  head word (FWFT); 0 when empty
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_full  output  1  count ≥ AFULL_LVL
- count  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full without pop
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Pointers wr_ptr, rd_ptr are $clog2(DEPTH) bits; wrap modulo DEPTH by natural overflow (no compare-to-DEPTH logic).
- Occupancy held in a separate count register of width $clog2(DEPTH+1) so count == DEPTH is representable.
- Accepted push (push && (!full || pop)): mem[wr_ptr] ← data_i, wr_ptr+1.
- Accepted pop (pop && !empty): rd_ptr+1.
- count next = count + accepted_push − accepted_pop.
- Full with push&&pop: both accepted, count stays DEPTH, head advances.
- Empty with push&&pop: push accepted, pop rejected, underflow set, count → 1.
- Push while full without pop: ignored, data discarded, overflow set.
- Pop while empty: ignored, underflow set.
- overflow/underflow stay set until rst or clr.
- clr: pointers, count, flags → 0; any push/pop in the clr cycle ignored; clr has priority over push/pop.
- data_o = empty ? 0 : mem[rd_ptr]; no combinational data_i→data_o bypass.
- Memory contents not reset; only control state is.

## Timing
- Reset (async assert, sync release on clk): count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_o=0.
- All flags and count registered/derived from registered state; update on the edge following the strobe.
- Write latency: push at edge N → empty deasserts and data_o valid in cycle after N (1 cycle).
- Pop at edge N → next head on data_o after N; data_o = 0 if that pop emptied the FIFO.
- Sustained push+pop every cycle at any non-empty occupancy: throughput 1 word/cycle, count constant.
- rst asserted mid-operation: state cleared immediately, independent of clk; stale memory never visible (data_o gated by empty).

## Structure
- Package nn_fifo_pkg: localparam helpers (ptr/count width functions from DEPTH), shared DATA_W default matching the Wishbone data bus (32).
- Sub-module nn_fifo_mem: DEPTH×DATA_W register array, one sync write port, one async read port; no reset. Control (pointers, count, flags) stays in nn_stream_fifo.
- Elaboration-time check: DEPTH power of two, 1 ≤ AFULL_LVL ≤ DEPTH.

## Test plan
- Reset: assert rst mid-stream with count=5 → count=0, empty=1, data_o=0 without a clk edge; flags 0.
- Fill/drain DEPTH=8: push 0x11..0x88 → full=1, almost_full=1 from count=6; pop 8 → words out in order 0x11..0x88, empty=1.
- Wrap-around: push 5, pop 5, push 8 (0xA0..0xA7) → full, read order 0xA0..0xA7 intact across pointer wrap.
- Boundaries: full + push&&pop with data 0xBEEF → count stays 8, overflow=0, 0xBEEF read last; empty + push&&pop → count=1, underflow=1.
- Errors/flush: push 9th word while full → overflow=1, 9th word never appears; clr → count=0, overflow=0, underflow=0.
- Parametric: DATA_W=16, DEPTH=4, AFULL_LVL=3 → count width 3, full at 4, almost_full at 3, random push/pop vs scoreboard for 10k cycles with no mismatch.
